// File: rtl/mac_pkg.sv
// Shared constants for the MAC datapath: state encodings, default widths, vector length.
package mac_pkg;

  localparam int unsigned PROD_W      = 16;
  localparam int unsigned ACC_W       = 24;
  localparam int unsigned VEC_LEN_DEF = 8;
  localparam int unsigned CNT_W       = 8;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/acc_add.sv
// Combinational W-bit unsigned adder returning the wrapped sum and the carry out of the MSB.
module acc_add #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/prod_accum.sv
// Sums VEC_LEN consecutive unsigned products into one result, handed off on a
// valid/ready output with a sticky overflow flag covering the whole vector.
module prod_accum
  import mac_pkg::*;
#(
  parameter int unsigned IN_WORD_SIZE  = PROD_W,
  parameter int unsigned ACC_WORD_SIZE = ACC_W,
  parameter int unsigned VEC_LEN       = VEC_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WORD_SIZE-1:0]  pin,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ACC_WORD_SIZE-1:0] acc_out,
  output logic                     ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  logic [0:0]               state, state_nx;
  logic [ACC_WORD_SIZE-1:0] acc, acc_nx, acc_out_nx, sum, pin_ext;
  logic [CNT_W-1:0]         cnt_nx;
  logic                     sticky, sticky_nx, ovf_nx, carry;

  assign pin_ext = ACC_WORD_SIZE'(pin);

  acc_add #(.W(ACC_WORD_SIZE)) u_acc_add (
    .a     (acc),
    .b     (pin_ext),
    .sum   (sum),
    .carry (carry)
  );

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);

  // Next-state and datapath update; no transfer leaves everything unchanged.
  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    sticky_nx  = sticky;
    acc_out_nx = acc_out;
    ovf_nx     = ovf;
    case (state)
      ST_ACC: begin
        if (in_valid) begin
          if (cnt == CNT_LAST) begin
            acc_out_nx = sum;
            ovf_nx     = sticky | carry;
            acc_nx     = '0;
            cnt_nx     = '0;
            state_nx   = ST_HOLD;
          end else begin
            acc_nx    = sum;
            sticky_nx = sticky | carry;
            cnt_nx    = cnt + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nx  = ST_ACC;
          sticky_nx = 1'b0;
        end
      end
      default: state_nx = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_ACC;
      acc     <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      acc_out <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      sticky  <= sticky_nx;
      acc_out <= acc_out_nx;
      ovf     <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: default instance plus a 16-bit accumulator instance for overflow.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] pin = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, ovf, out_valid;
  logic [23:0] acc_out;
  logic [7:0]  cnt;

  logic [15:0] pin16 = '0;
  logic        in_valid16 = 1'b0, out_ready16 = 1'b1;
  logic        in_ready16, ovf16, out_valid16;
  logic [15:0] acc_out16;
  logic [7:0]  cnt16;

  typedef struct packed {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] vec [8];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        pv0, pv1;

  always #5 clk = ~clk;

  prod_accum dut (
    .clk(clk), .rst(rst), .pin(pin), .in_valid(in_valid), .in_ready(in_ready),
    .acc_out(acc_out), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready), .cnt(cnt)
  );

  prod_accum #(.ACC_WORD_SIZE(16)) dut16 (
    .clk(clk), .rst(rst), .pin(pin16), .in_valid(in_valid16), .in_ready(in_ready16),
    .acc_out(acc_out16), .ovf(ovf16), .out_valid(out_valid16), .out_ready(out_ready16),
    .cnt(cnt16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: compare each new result against the oldest expected entry.
  always @(negedge clk) begin
    if (rst) pv0 <= 1'b0;
    else begin
      if (out_valid && !pv0) begin
        if (q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result: got acc_out=%0d, expected none", acc_out);
        end else begin
          chk("acc_out", 32'(acc_out), 32'(q0[0].acc));
          chk("ovf", 32'(ovf), 32'(q0[0].ovf));
          void'(q0.pop_front());
        end
      end
      pv0 <= out_valid;
    end
  end

  always @(negedge clk) begin
    if (rst) pv1 <= 1'b0;
    else begin
      if (out_valid16 && !pv1) begin
        if (q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result16: got acc_out=%0d, expected none", acc_out16);
        end else begin
          chk("acc_out16", 32'(acc_out16), 32'(q1[0].acc));
          chk("ovf16", 32'(ovf16), 32'(q1[0].ovf));
          void'(q1.pop_front());
        end
      end
      pv1 <= out_valid16;
    end
  end

  // Offer one product until accepted; checks cnt before the accepting edge.
  task automatic push_one(input bit sel, input logic [15:0] v, input int idx);
    int   guard = 0;
    logic rdy;
    if (sel) begin pin16 = v; in_valid16 = 1'b1; end
    else     begin pin   = v; in_valid   = 1'b1; end
    do begin
      @(negedge clk);
      rdy = sel ? in_ready16 : in_ready;
      if (rdy) chk(sel ? "cnt16_before" : "cnt_before", 32'(sel ? cnt16 : cnt), 32'(idx));
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 64);
    if (!rdy) begin
      n_checks++; n_errors++;
      $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 64 cycles");
    end
    if (sel) in_valid16 = 1'b0; else in_valid = 1'b0;
  endtask

  // Send vec[0..7]; optional one-cycle bubbles; checks 1-cycle result latency.
  task automatic send_vec(input bit sel, input bit gaps, input logic [23:0] e_acc,
                          input logic e_ovf);
    exp_t e;
    e.acc = e_acc; e.ovf = e_ovf;
    if (sel) q1.push_back(e); else q0.push_back(e);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        chk("cnt_bubble", 32'(sel ? cnt16 : cnt), 32'(i));
        @(posedge clk); #1;
      end
      push_one(sel, vec[i], i);
    end
    @(negedge clk);
    chk(sel ? "latency16" : "latency", 32'(sel ? out_valid16 : out_valid), 32'd1);
    chk(sel ? "cnt16_after" : "cnt_after", 32'(sel ? cnt16 : cnt), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset asserted between edges: outputs must clear without a clock.
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc_out", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    vec = '{16'd5000, 16'd1200, 16'd220, 16'd342, 16'd1309, 16'd4455, 16'd3220, 16'd1431};
    send_vec(1'b0, 1'b0, 24'd17177, 1'b0);
    send_vec(1'b0, 1'b1, 24'd17177, 1'b0);

    // Backpressure: result must hold and extra input must be ignored.
    out_ready = 1'b0;
    send_vec(1'b0, 1'b0, 24'd17177, 1'b0);
    pin = 16'd9999; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_acc_out", 32'(acc_out), 32'd17177);
      chk("bp_cnt", 32'(cnt), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) vec[i] = 16'd100;
    send_vec(1'b0, 1'b0, 24'd800, 1'b0);

    for (int i = 0; i < 8; i++) vec[i] = 16'd65025;
    send_vec(1'b1, 1'b0, 24'd61448, 1'b1);
    for (int i = 0; i < 8; i++) vec[i] = 16'd1;
    send_vec(1'b1, 1'b0, 24'd8, 1'b0);

    // Abort after 4 transfers, then a clean vector must show no residue.
    for (int i = 0; i < 4; i++) push_one(1'b0, 16'd7, i);
    #3 rst = 1'b1;
    #1;
    chk("abort_cnt", 32'(cnt), 32'd0);
    chk("abort_acc_out", 32'(acc_out), 32'd0);
    chk("abort_acc_out16", 32'(acc_out16), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) vec[i] = 16'd10;
    send_vec(1'b0, 1'b0, 24'd80, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
